mc_ctrl: RTL

Multi-cycle main controller for the MIPS datapath. It is the driving end of the ALU interface: it decodes the latched instruction, sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, and issues ALUOp codes. It also consumes the ALU Zero and Isbgez flags to resolve branches and drives every PC, IR, register-file and memory write enable.

---
 rtl/mc_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB/BR)
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] ctrl_Op,
  input  logic [5:0] ctrl_Funct,
  input  logic [4:0] ctrl_Rt,
  input  logic       ctrl_Zero,
  input  logic       ctrl_Isbgez,
  output logic       ctrl_PCWr,
  output logic       ctrl_IRWr,
  output logic       ctrl_RegWr,
  output logic       ctrl_MemWr,
  output logic [2:0] ctrl_ALUOp,
  output logic       ctrl_ALUSrc,
  output logic       ctrl_ExtOp,
  output logic [1:0] ctrl_RegDst,
  output logic [1:0] ctrl_MemtoReg,
  output logic [1:0] ctrl_NPCOp,
  output logic       ctrl_Done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw;
  logic w_beq, w_j, w_jal, w_bgez;
  logic [2:0] w_exec_aluop;

  assign w_rtype = (ctrl_Op == 6'b000000);
  assign w_addu  = w_rtype && (ctrl_Funct == 6'b100001);
  assign w_subu  = w_rtype && (ctrl_Funct == 6'b100011);
  assign w_jr    = w_rtype && (ctrl_Funct == 6'b001000);
  assign w_ori   = (ctrl_Op == 6'b001101);
  assign w_lui   = (ctrl_Op == 6'b001111);
  assign w_lw    = (ctrl_Op == 6'b100011);
  assign w_sw    = (ctrl_Op == 6'b101011);
  assign w_beq   = (ctrl_Op == 6'b000100);
  assign w_j     = (ctrl_Op == 6'b000010);
  assign w_jal   = (ctrl_Op == 6'b000011);
  assign w_bgez  = (ctrl_Op == 6'b000001) && (ctrl_Rt == 5'b00001);

  // ALU operation chosen in EXEC; WB re-issues it so the ALU result stays stable.
  always_comb begin
    w_exec_aluop = 3'd0;
    if (w_addu || w_lw || w_sw) w_exec_aluop = 3'd2;
    else if (w_subu)            w_exec_aluop = 3'd3;
    else if (w_ori)             w_exec_aluop = 3'd1;
    else if (w_lui)             w_exec_aluop = 3'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = S_FETCH;
    ctrl_PCWr     = 1'b0;
    ctrl_IRWr     = 1'b0;
    ctrl_RegWr    = 1'b0;
    ctrl_MemWr    = 1'b0;
    ctrl_ALUOp    = 3'd0;
    ctrl_ALUSrc   = 1'b0;
    ctrl_ExtOp    = 1'b0;
    ctrl_RegDst   = 2'd0;
    ctrl_MemtoReg = 2'd0;
    ctrl_NPCOp    = 2'd0;
    ctrl_Done     = 1'b0;
    case (r_state)
      S_FETCH: begin
        ctrl_IRWr = 1'b1;
        ctrl_PCWr = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        if (w_addu || w_subu || w_ori || w_lui || w_lw || w_sw) begin
          w_next = S_EXEC;
        end else if (w_beq || w_bgez) begin
          w_next = S_BR;
        end else if (w_jal) begin
          w_next = S_WB;
        end else if (w_j) begin
          ctrl_PCWr  = 1'b1;
          ctrl_NPCOp = 2'd2;
          ctrl_Done  = 1'b1;
        end else if (w_jr) begin
          ctrl_PCWr  = 1'b1;
          ctrl_NPCOp = 2'd3;
          ctrl_Done  = 1'b1;
        end else begin
          ctrl_Done = 1'b1;
        end
      end
      S_EXEC: begin
        ctrl_ALUOp  = w_exec_aluop;
        ctrl_ALUSrc = w_ori || w_lui || w_lw || w_sw;
        ctrl_ExtOp  = w_lw || w_sw;
        w_next      = (w_lw || w_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (w_sw) begin
          ctrl_MemWr  = 1'b1;
          ctrl_ALUOp  = 3'd2;
          ctrl_ALUSrc = 1'b1;
          ctrl_ExtOp  = 1'b1;
          ctrl_Done   = 1'b1;
        end else if (w_lw) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        ctrl_RegWr = 1'b1;
        ctrl_Done  = 1'b1;
        ctrl_ALUOp = w_exec_aluop;
        if (w_addu || w_subu) begin
          ctrl_RegDst = 2'd1;
        end else if (w_lw) begin
          ctrl_MemtoReg = 2'd1;
        end else if (w_jal) begin
          ctrl_RegDst   = 2'd2;
          ctrl_MemtoReg = 2'd2;
          ctrl_PCWr     = 1'b1;
          ctrl_NPCOp    = 2'd2;
        end
      end
      S_BR: begin
        ctrl_ALUOp = 3'd3;
        ctrl_ExtOp = 1'b1;
        ctrl_NPCOp = 2'd1;
        ctrl_Done  = 1'b1;
        ctrl_PCWr  = (w_beq && ctrl_Zero) || (w_bgez && ctrl_Isbgez);
      end
      default: w_next = S_FETCH;
    endcase
    // Reset overrides everything so an abandoned instruction issues no writes.
    if (reset) begin
      ctrl_PCWr     = 1'b0;
      ctrl_IRWr     = 1'b0;
      ctrl_RegWr    = 1'b0;
      ctrl_MemWr    = 1'b0;
      ctrl_ALUOp    = 3'd0;
      ctrl_ALUSrc   = 1'b0;
      ctrl_ExtOp    = 1'b0;
      ctrl_RegDst   = 2'd0;
      ctrl_MemtoReg = 2'd0;
      ctrl_NPCOp    = 2'd0;
      ctrl_Done     = 1'b0;
    end
  end

endmodule
